// File: rtl/packet_parser_if.sv
// Receive-FIFO word stream into the packet parser: one big-endian 32-bit word per valid cycle.
// There is no ready signal because the parser accepts a word every valid cycle.
interface packet_parser_if;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_empty;
    logic [31:0] in_data;

    modport master (output in_valid, in_sop, in_eop, in_empty, in_data);
    modport slave  (input  in_valid, in_sop, in_eop, in_empty, in_data);
endinterface

// File: rtl/packet_parser.sv
// Ethernet/IPv4/L4 header field capture with payload forwarding; every output is registered (1-cycle latency).
// There is no backpressure: each valid word is consumed in the cycle it is presented.
module packet_parser (
    input  logic                  clk,
    input  logic                  rst,
    packet_parser_if.slave        in_if,
    output logic                  clear,
    output logic [31:0]           data_out,
    output logic                  data_valid,
    output logic [47:0]           dest_mac,
    output logic [47:0]           src_mac,
    output logic [15:0]           ethertype,
    output logic [31:0]           src_ip,
    output logic [31:0]           dst_ip,
    output logic [15:0]           src_port,
    output logic [15:0]           dst_port,
    output logic                  header_valid,
    output logic                  frame_done,
    output logic                  frame_error
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    // CLS_IPPEND: IPv4 with IHL=5 seen at w3, protocol not yet known
    localparam logic [2:0] CLS_UNK    = 3'd0;
    localparam logic [2:0] CLS_NONIP  = 3'd1;
    localparam logic [2:0] CLS_IPPEND = 3'd2;
    localparam logic [2:0] CLS_IP     = 3'd3;
    localparam logic [2:0] CLS_UDP    = 3'd4;
    localparam logic [2:0] CLS_TCP    = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [3:0]  widx_q, widx_d;
    logic [2:0]  cls_q, cls_d;
    logic        hdr_seen_q, hdr_seen_d;
    logic        clear_q, clear_d;
    logic [31:0] data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic [47:0] dest_mac_q, dest_mac_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [15:0] ethertype_q, ethertype_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic [15:0] dst_port_q, dst_port_d;
    logic        header_valid_q, header_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_error_q, frame_error_d;

    logic        accept;
    logic [3:0]  cur_idx;
    logic        is_ip_q;
    logic        is_l4_q;
    logic        cls_known;
    logic [3:0]  hdr_last;
    logic [3:0]  pay_start;
    logic        payload;
    logic [31:0] byte_mask;

    assign is_ip_q = (cls_q == CLS_IP) || (cls_q == CLS_UDP) || (cls_q == CLS_TCP);
    assign is_l4_q = (cls_q == CLS_UDP) || (cls_q == CLS_TCP);

    always_comb begin
        accept  = in_if.in_valid && (in_if.in_sop || (state_q != ST_IDLE));
        cur_idx = in_if.in_sop ? 4'd0 : ((widx_q == 4'hF) ? 4'hF : widx_q + 4'd1);

        state_d        = state_q;
        widx_d         = widx_q;
        cls_d          = cls_q;
        hdr_seen_d     = hdr_seen_q;
        dest_mac_d     = dest_mac_q;
        src_mac_d      = src_mac_q;
        ethertype_d    = ethertype_q;
        src_ip_d       = src_ip_q;
        dst_ip_d       = dst_ip_q;
        src_port_d     = src_port_q;
        dst_port_d     = dst_port_q;
        clear_d        = 1'b0;
        data_out_d     = 32'd0;
        data_valid_d   = 1'b0;
        header_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        frame_error_d  = 1'b0;
        cls_known      = 1'b0;
        hdr_last       = 4'hF;
        pay_start      = 4'hF;
        payload        = 1'b0;
        byte_mask      = 32'hFFFF_FFFF;

        if (accept) begin
            widx_d = cur_idx;
            if (in_if.in_sop) begin
                // a sop mid-frame closes the old frame as aborted
                clear_d       = 1'b1;
                frame_done_d  = (state_q != ST_IDLE);
                frame_error_d = (state_q != ST_IDLE);
                cls_d         = CLS_UNK;
                hdr_seen_d    = 1'b0;
                dest_mac_d    = 48'd0;
                src_mac_d     = 48'd0;
                ethertype_d   = 16'd0;
                src_ip_d      = 32'd0;
                dst_ip_d      = 32'd0;
                src_port_d    = 16'd0;
                dst_port_d    = 16'd0;
            end

            case (cur_idx)
                4'd0: dest_mac_d[47:16] = in_if.in_data;
                4'd1: begin
                    dest_mac_d[15:0]  = in_if.in_data[31:16];
                    src_mac_d[47:32]  = in_if.in_data[15:0];
                end
                4'd2: src_mac_d[31:0] = in_if.in_data;
                4'd3: begin
                    ethertype_d = in_if.in_data[31:16];
                    cls_d = ((in_if.in_data[31:16] == 16'h0800) && (in_if.in_data[11:8] == 4'd5))
                            ? CLS_IPPEND : CLS_NONIP;
                end
                4'd5: if (cls_q == CLS_IPPEND) begin
                    cls_d = (in_if.in_data[7:0] == 8'd6)  ? CLS_TCP :
                            (in_if.in_data[7:0] == 8'd17) ? CLS_UDP : CLS_IP;
                end
                4'd6: if (is_ip_q) src_ip_d[31:16] = in_if.in_data[15:0];
                4'd7: if (is_ip_q) begin
                    src_ip_d[15:0]  = in_if.in_data[31:16];
                    dst_ip_d[31:16] = in_if.in_data[15:0];
                end
                4'd8: if (is_ip_q) begin
                    dst_ip_d[15:0] = in_if.in_data[31:16];
                    if (is_l4_q) src_port_d = in_if.in_data[15:0];
                end
                4'd9: if (is_l4_q) dst_port_d = in_if.in_data[31:16];
                default: ;
            endcase

            case (cls_d)
                CLS_NONIP: begin cls_known = 1'b1; hdr_last = 4'd3; pay_start = 4'd4;  end
                CLS_IP:    begin cls_known = 1'b1; hdr_last = 4'd8; pay_start = 4'd9;  end
                CLS_UDP:   begin cls_known = 1'b1; hdr_last = 4'd9; pay_start = 4'd10; end
                CLS_TCP:   begin cls_known = 1'b1; hdr_last = 4'd9; pay_start = 4'd13; end
                default: ;
            endcase

            payload        = cls_known && (cur_idx >= pay_start);
            header_valid_d = cls_known && (cur_idx == hdr_last);
            hdr_seen_d     = hdr_seen_d | header_valid_d;

            if (payload) begin
                if (in_if.in_eop) byte_mask = 32'hFFFF_FFFF << {in_if.in_empty, 3'b000};
                data_valid_d = 1'b1;
                data_out_d   = in_if.in_data & byte_mask;
            end

            state_d = payload ? ST_PAYLOAD : ST_HEADER;
            if (in_if.in_eop) begin
                state_d       = ST_IDLE;
                frame_done_d  = 1'b1;
                frame_error_d = frame_error_d | !hdr_seen_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            widx_q         <= 4'd0;
            cls_q          <= CLS_UNK;
            hdr_seen_q     <= 1'b0;
            clear_q        <= 1'b0;
            data_out_q     <= 32'd0;
            data_valid_q   <= 1'b0;
            dest_mac_q     <= 48'd0;
            src_mac_q      <= 48'd0;
            ethertype_q    <= 16'd0;
            src_ip_q       <= 32'd0;
            dst_ip_q       <= 32'd0;
            src_port_q     <= 16'd0;
            dst_port_q     <= 16'd0;
            header_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            widx_q         <= widx_d;
            cls_q          <= cls_d;
            hdr_seen_q     <= hdr_seen_d;
            clear_q        <= clear_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            dest_mac_q     <= dest_mac_d;
            src_mac_q      <= src_mac_d;
            ethertype_q    <= ethertype_d;
            src_ip_q       <= src_ip_d;
            dst_ip_q       <= dst_ip_d;
            src_port_q     <= src_port_d;
            dst_port_q     <= dst_port_d;
            header_valid_q <= header_valid_d;
            frame_done_q   <= frame_done_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign clear        = clear_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign dest_mac     = dest_mac_q;
    assign src_mac      = src_mac_q;
    assign ethertype    = ethertype_q;
    assign src_ip       = src_ip_q;
    assign dst_ip       = dst_ip_q;
    assign src_port     = src_port_q;
    assign dst_port     = dst_port_q;
    assign header_valid = header_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_error  = frame_error_q;
endmodule

// File: tb/tb_packet_parser.sv
// Scoreboard bench for packet_parser: frame builder + reference model push cycle-stamped
// expectations; a negedge monitor pops them whenever the DUT presents an output.
module tb_packet_parser;
    logic        clk, rst;
    logic        clear, data_valid, header_valid, frame_done, frame_error;
    logic [31:0] data_out, src_ip, dst_ip;
    logic [47:0] dest_mac, src_mac;
    logic [15:0] ethertype, src_port, dst_port;

    packet_parser_if bus();

    packet_parser dut (
        .clk(clk), .rst(rst), .in_if(bus),
        .clear(clear), .data_out(data_out), .data_valid(data_valid),
        .dest_mac(dest_mac), .src_mac(src_mac), .ethertype(ethertype),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
        .header_valid(header_valid), .frame_done(frame_done), .frame_error(frame_error)
    );

    typedef struct { int cyc; logic [31:0] dat; } data_exp_t;
    typedef struct { int cyc; logic err; } done_exp_t;
    typedef struct { int cyc; logic [207:0] fields; } hdr_exp_t;

    data_exp_t exp_data[$];
    done_exp_t exp_done[$];
    hdr_exp_t  exp_hdr[$];
    int        exp_clear[$];

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  pending_abort = 0;
    logic [31:0] fw [0:31];

    data_exp_t md;
    hdr_exp_t  mh;
    done_exp_t mdn;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_empty = 2'd0;
        bus.in_data  = $urandom;
    endtask

    // kind: 0 ARP, 1 IPv4/ICMP, 2 UDP, 3 TCP, 4 IPv4 with IHL=6 (treated as non-IP)
    task automatic build(input int kind);
        for (int i = 0; i < 32; i++) fw[i] = $urandom;
        case (kind)
            0: fw[3][31:16] = 16'h0806;
            1: begin fw[3][31:8] = 24'h080045; fw[5][7:0] = 8'd1;  end
            2: begin fw[3][31:8] = 24'h080045; fw[5][7:0] = 8'd17; end
            3: begin fw[3][31:8] = 24'h080045; fw[5][7:0] = 8'd6;  end
            default: begin fw[3][31:8] = 24'h080046; fw[5][7:0] = 8'd17; end
        endcase
    endtask

    task automatic set_addr(input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp);
        fw[6][15:0]  = sip[31:16];
        fw[7]        = {sip[15:0], dip[31:16]};
        fw[8]        = {dip[15:0], sp};
        fw[9][31:16] = dp;
    endtask

    // Reference: classify from the header bytes actually present in an n-word frame.
    task automatic plan(input int n, output int h, output int p, output logic [207:0] f);
        logic [15:0] et;
        logic [7:0]  proto;
        bit          ip, l4;
        logic [31:0] sip, dip;
        logic [15:0] sp, dp;
        h = 99; p = 99; ip = 0; l4 = 0;
        et = fw[3][31:16];
        if (n >= 4) begin
            if (et != 16'h0800 || fw[3][11:8] != 4'd5) begin
                h = 3; p = 4;
            end else if (n >= 6) begin
                ip = 1;
                proto = fw[5][7:0];
                if (proto == 8'd6)       begin h = 9; p = 13; l4 = 1; end
                else if (proto == 8'd17) begin h = 9; p = 10; l4 = 1; end
                else                     begin h = 8; p = 9; end
            end
        end
        sip = ip ? {fw[6][15:0], fw[7][31:16]} : 32'd0;
        dip = ip ? {fw[7][15:0], fw[8][31:16]} : 32'd0;
        sp  = l4 ? fw[8][15:0]  : 16'd0;
        dp  = l4 ? fw[9][31:16] : 16'd0;
        f = {fw[0], fw[1], fw[2], et, sip, dip, sp, dp};
    endtask

    task automatic send_frame(input int n, input bit eop, input logic [1:0] empty,
                              input int gap_at, input int gap_len);
        int h, p;
        logic [207:0] f;
        logic [31:0] w;
        data_exp_t de;
        hdr_exp_t  he;
        done_exp_t dn;
        bit last;
        plan(n, h, p, f);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) for (int g = 0; g < gap_len; g++) begin step(); drive_idle(); end
            step();
            last = eop && (i == n - 1);
            bus.in_valid = 1'b1;
            bus.in_sop   = (i == 0);
            bus.in_eop   = last;
            bus.in_empty = last ? empty : 2'($urandom);
            bus.in_data  = fw[i];
            if (i == 0) begin
                exp_clear.push_back(cyc + 1);
                if (pending_abort) begin dn.cyc = cyc + 1; dn.err = 1'b1; exp_done.push_back(dn); end
            end
            if (i == h) begin he.cyc = cyc + 1; he.fields = f; exp_hdr.push_back(he); end
            if (i >= p) begin
                w = fw[i];
                if (last) for (int b = 0; b < int'(empty); b++) w[8*b +: 8] = 8'h00;
                de.cyc = cyc + 1; de.dat = w; exp_data.push_back(de);
            end
            if (last) begin dn.cyc = cyc + 1; dn.err = (n - 1 < h); exp_done.push_back(dn); end
        end
        step();
        drive_idle();
        pending_abort = !eop;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (clear) begin
                if (exp_clear.size() == 0) chk("clear_unexpected", clear, 1'b0);
                else chk("clear_cycle", cyc, exp_clear.pop_front());
            end
            if (data_valid) begin
                if (exp_data.size() == 0) chk("data_unexpected", data_valid, 1'b0);
                else begin
                    md = exp_data.pop_front();
                    chk("data_cycle", cyc, md.cyc);
                    chk("data_word", data_out, md.dat);
                end
            end else chk("data_idle_zero", data_out, 32'd0);
            if (header_valid) begin
                if (exp_hdr.size() == 0) chk("hdr_unexpected", header_valid, 1'b0);
                else begin
                    mh = exp_hdr.pop_front();
                    chk("hdr_cycle", cyc, mh.cyc);
                    chk("hdr_fields", {dest_mac, src_mac, ethertype, src_ip, dst_ip, src_port, dst_port},
                        mh.fields);
                end
            end
            if (frame_done) begin
                if (exp_done.size() == 0) chk("done_unexpected", frame_done, 1'b0);
                else begin
                    mdn = exp_done.pop_front();
                    chk("done_cycle", cyc, mdn.cyc);
                    chk("done_error", frame_error, mdn.err);
                end
            end else chk("error_without_done", frame_error, 1'b0);
        end
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {clear, data_out, data_valid, dest_mac, src_mac, ethertype, src_ip, dst_ip,
                              src_port, dst_port, header_valid, frame_done, frame_error}, 245'd0);
        step();
        rst = 1'b0;

        build(2);
        set_addr(32'hC0A80105, 32'h0A000002, 16'd4000, 16'd53);
        send_frame(12, 1'b1, 2'd0, -1, 0);
        repeat (2) step();
        chk("udp_src_ip", src_ip, 32'hC0A80105);
        chk("udp_dst_port", dst_port, 16'h0035);

        build(0);
        send_frame(8, 1'b1, 2'd2, -1, 0);
        repeat (2) step();
        chk("arp_src_ip", src_ip, 32'd0);
        chk("arp_dst_ip", dst_ip, 32'd0);

        build(3);
        send_frame(15, 1'b1, 2'd0, 11, 3);

        build(1);
        send_frame(6, 1'b1, 2'd0, -1, 0);

        for (int i = 0; i < 3; i++) begin
            step(); bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_data = $urandom;
        end
        step(); drive_idle();

        build(2);
        send_frame(7, 1'b0, 2'd0, -1, 0);
        build(1);
        fw[0] = 32'hA1B2C3D4;
        fw[1][31:16] = 16'hE5F6;
        send_frame(10, 1'b1, 2'd1, -1, 0);
        repeat (2) step();
        chk("abort_new_dest_mac", dest_mac, 48'hA1B2C3D4E5F6);

        build(2);
        send_frame(10, 1'b0, 2'd0, -1, 0);
        step();
        bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_data = fw[10];
        rst = 1'b1;
        #1;
        chk("reset_midframe_outputs", {clear, data_out, data_valid, dest_mac, src_mac, ethertype, src_ip,
                                       dst_ip, src_port, dst_port, header_valid, frame_done, frame_error},
            245'd0);
        pending_abort = 0;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_data = $urandom;
        end
        step(); drive_idle();
        build(2);
        send_frame(12, 1'b1, 2'd3, -1, 0);

        for (int k = 0; k < 40; k++) begin
            int kind, n, gat;
            bit e;
            kind = $urandom_range(0, 4);
            n    = $urandom_range(2, 24);
            e    = ($urandom_range(0, 5) != 0);
            gat  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
            build(kind);
            send_frame(n, e, 2'($urandom), gat, $urandom_range(1, 3));
        end
        build(3);
        send_frame(16, 1'b1, 2'd0, -1, 0);

        repeat (5) step();
        chk("left_data", exp_data.size(), 0);
        chk("left_hdr", exp_hdr.size(), 0);
        chk("left_done", exp_done.size(), 0);
        chk("left_clear", exp_clear.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/packet_parser.md
# packet_parser

Front-end stage of the sniffer datapath. It accepts a 32-bit big-endian Ethernet frame stream from the receive FIFO and tracks word position within each frame. It captures MAC, EtherType, IPv4 address and TCP/UDP port fields for the MAC/IP/port comparators, and forwards only payload words, with a per-frame clear, to the string comparators directly downstream.

## Interface
- No parameters. Supported header layout: untagged Ethernet II, IPv4 with IHL=5, TCP data offset=5.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: input word valid.
- `in_sop` input 1: first word of frame (qualified by `in_valid`).
- `in_eop` input 1: last word of frame (qualified by `in_valid`).
- `in_empty` input 2: number of unused trailing bytes in the eop word (0–3), low-order bytes unused.
- `in_data` input 32: frame bytes; byte 4n is in `[31:24]` of word n.
- `clear` output 1: one-cycle pulse per accepted sop; drives comparator `clear`.
- `data_out` output 32: payload word to comparators; 0 when `data_valid`=0.
- `data_valid` output 1: `data_out` carries payload.
- `dest_mac`, `src_mac` output 48 each: captured MAC fields.
- `ethertype` output 16: captured EtherType.
- `src_ip`, `dst_ip` output 32 each: captured IPv4 addresses, 0 if not IPv4.
- `src_port`, `dst_port` output 16 each: captured L4 ports, 0 if not TCP/UDP.
- `header_valid` output 1: one-cycle pulse when all fields for the frame type are captured.
- `frame_done` output 1: one-cycle pulse after the eop word or an abort.
- `frame_error` output 1: qualifies `frame_done`; frame was truncated or aborted.

## Operation
- States: IDLE, HEADER, PAYLOAD.
  - IDLE → HEADER on `in_valid & in_sop`.
  - HEADER → PAYLOAD when word index reaches P.
  - Any state → IDLE on accepted eop.
- Word index `widx`: 4-bit counter. Set to 0 on the sop word, +1 per accepted word, saturates at 15. Holds when `in_valid`=0.
- Field capture by word index:
  - w0 → `dest_mac[47:16]`.
  - w1 → `dest_mac[15:0]`, `src_mac[47:32]`.
  - w2 → `src_mac[31:0]`.
  - w3 → `ethertype`=`[31:16]`, IHL=`[11:8]`.
  - w5 → protocol=`[7:0]`.
  - w6 → `src_ip[31:16]`=`[15:0]`.
  - w7 → `src_ip[15:0]`, `dst_ip[31:16]`.
  - w8 → `dst_ip[15:0]`=`[31:16]`, `src_port`=`[15:0]`.
  - w9 → `dst_port`=`[31:16]`.
- Frame class, decided at w3 and w5:
  - Non-IP: `ethertype`≠0x0800 or IHL≠5. Last header word H=3, payload start P=4.
  - IPv4 other: protocol∉{6,17}. H=8, P=9.
  - UDP: protocol=17. H=9, P=10.
  - TCP: protocol=6. H=9, P=13.
- IP fields are captured only for IPv4 frames; port fields only for TCP/UDP. Uncaptured fields are cleared to 0 at sop.
- Payload words (widx ≥ P) are forwarded whole. The first UDP/TCP payload word includes 2 trailing header bytes, which is accepted because the comparators scan with a sliding window.
- eop word with `in_empty`=k: the low k bytes of `data_out` are forced to 0.
- sop while not IDLE aborts the previous frame: `frame_done`=`frame_error`=1, then the new frame starts normally. The new word is treated as w0 and `clear` pulses.
- eop before widx reaches H: `header_valid` is never pulsed; `frame_done`=`frame_error`=1.
- `in_valid` without sop in IDLE: word dropped, no outputs change.

## Timing
- All outputs are registered; latency is 1 cycle from input word to output.
- `clear` is high in the cycle after the sop word. That cycle's `data_valid` is 0.
- `header_valid` is high the cycle after word H is accepted. Field outputs are stable from that cycle until the next sop.
- `data_out`/`data_valid` follow each accepted payload word by 1 cycle. Input gaps produce `data_valid`=0 and `data_out`=0.
- `frame_done` is high the cycle after the eop word; it coincides with that word's `data_valid` if the word is payload.
- Reset (any time, including mid-frame): state IDLE, widx=0, all outputs 0. The next word must be sop to be accepted.

## Test plan
- UDP frame, 12 words, dst 10.0.0.2:53, src 192.168.1.5:4000, no gaps.
  - `header_valid` 1 cycle after w9.
  - `src_ip`=0xC0A80105, `dst_port`=0x0035.
  - `data_valid` high for exactly the w10, w11 outputs.
  - `frame_done`=1, `frame_error`=0.
- ARP frame (`ethertype` 0x0806), 8 words, eop `in_empty`=2.
  - P=4; 4 payload words forwarded.
  - Last `data_out` low 16 bits = 0.
  - `src_ip`=`dst_ip`=0.
- TCP frame, 15 words, with `in_valid` low for 3 cycles at w11.
  - Payload is exactly w13, w14.
  - widx holds during the gap; no spurious `data_valid`.
- Truncated frame: eop at w5 of an IPv4 frame.
  - No `header_valid`.
  - `frame_done`=`frame_error`=1 one cycle after w5.
- sop arriving at w7 of a frame in progress.
  - Abort pulse is reported.
  - `clear` pulses and the new frame parses correctly, checked by its `dest_mac` value.
- `rst` asserted at w10 of a UDP frame.
  - All outputs 0 immediately.
  - Post-reset non-sop words are ignored; the next sop frame parses normally.
